// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the adder back-end FSM state encoding.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF    = 8'hFF;
    localparam int          HIDDEN_BIT = 45;
    localparam int          FRAC_LSB   = 22;
    localparam int          MANT_W     = 48;
    localparam int          EXP_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/fp_rounder.sv
// Round-to-nearest-even on a normalised 46-bit magnitude and FP32 packing.
module fp_rounder
    import fp32_pkg::*;
(
    input  logic [HIDDEN_BIT:0] mant,
    input  logic [EXP_W-1:0]    exp_in,
    input  logic                sign,
    output logic [31:0]         packed_res
);

    logic             guard_s;
    logic             sticky_s;
    logic             lsb_s;
    logic             inc_s;
    logic [24:0]      sum_s;
    logic [23:0]      mant_s;
    logic [EXP_W-1:0] exp_s;
    logic [7:0]       field_s;

    // RNE increment, carry renormalisation and field packing
    always_comb begin
        guard_s    = mant[FRAC_LSB-1];
        sticky_s   = |mant[FRAC_LSB-2:0];
        lsb_s      = mant[FRAC_LSB];
        inc_s      = guard_s & (sticky_s | lsb_s);
        sum_s      = {1'b0, mant[HIDDEN_BIT:FRAC_LSB]} + {24'd0, inc_s};
        mant_s     = sum_s[23:0];
        exp_s      = exp_in;
        field_s    = 8'd0;
        packed_res = 32'd0;
        if (sum_s[24]) begin
            mant_s = sum_s[24:1];
            exp_s  = exp_in + 10'd1;
        end else begin
            mant_s = sum_s[23:0];
            exp_s  = exp_in;
        end
        // A denormal whose round-up sets the hidden bit picks up field 1 here
        if (mant_s[23]) begin
            field_s = exp_s[7:0];
        end else begin
            field_s = 8'd0;
        end
        if (exp_s >= 10'd255) begin
            packed_res = {sign, EXP_INF, 23'd0};
        end else begin
            packed_res = {sign, field_s, mant_s[22:0]};
        end
    end

endmodule

// File: rtl/fp_add_normalizer.sv
// FP32 adder back end: mantissa sum, iterative normalisation, RNE rounding and
// result delivery over valid/ready handshakes.
module fp_add_normalizer
    import fp32_pkg::*;
#(
    parameter int NORM_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              NaN_res,
    input  logic              inf_res,
    input  logic              legal,
    input  logic              res_sig,
    input  logic [7:0]        exp_max,
    input  logic [MANT_W-1:0] mant_op_1,
    input  logic [MANT_W-1:0] mant_op_2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       result
);

    fsm_state_e        state_r;
    logic [MANT_W-1:0] op1_r;
    logic [MANT_W-1:0] op2_r;
    logic [MANT_W-2:0] mag_r;
    logic [EXP_W-1:0]  exp_r;
    logic              sign_r;
    logic              zero_r;
    logic              zero_sign_r;
    logic              in_ready_r;
    logic              res_valid_r;
    logic [31:0]       result_r;

    logic [MANT_W-1:0] sum_s;
    logic [MANT_W-2:0] mag_s;
    logic [3:0]        lz_s;
    logic              run_s;
    logic [EXP_W-1:0]  exp_m1_s;
    logic [3:0]        shamt_s;
    logic [MANT_W-2:0] norm_mag_s;
    logic [EXP_W-1:0]  norm_exp_s;
    logic [31:0]       rounded_s;

    // Two's-complement sum and its magnitude; operands are bounded so bit 47 is the sign
    always_comb begin
        sum_s = op1_r + op2_r;
        mag_s = sum_s[MANT_W-2:0];
        if (sum_s[MANT_W-1]) begin
            mag_s = ~sum_s[MANT_W-2:0] + 47'd1;
        end else begin
            mag_s = sum_s[MANT_W-2:0];
        end
    end

    // One normalisation step; left shifts never push the exponent below 1
    always_comb begin
        lz_s       = 4'd0;
        run_s      = 1'b1;
        exp_m1_s   = exp_r - 10'd1;
        shamt_s    = 4'd0;
        norm_mag_s = mag_r;
        norm_exp_s = exp_r;
        for (int k = 0; k < NORM_STEP; k++) begin
            if (run_s && !mag_r[HIDDEN_BIT-k]) begin
                lz_s = lz_s + 4'd1;
            end else begin
                run_s = 1'b0;
            end
        end
        if ({6'd0, lz_s} > exp_m1_s) begin
            shamt_s = exp_m1_s[3:0];
        end else begin
            shamt_s = lz_s;
        end
        if (mag_r[MANT_W-2]) begin
            norm_mag_s = {1'b0, mag_r[MANT_W-2:2], mag_r[1] | mag_r[0]};
            norm_exp_s = exp_r + 10'd1;
        end else begin
            norm_mag_s = mag_r << shamt_s;
            norm_exp_s = exp_r - {6'd0, shamt_s};
        end
    end

    fp_rounder u_rounder (
        .mant       (mag_r[HIDDEN_BIT:0]),
        .exp_in     (exp_r),
        .sign       (sign_r),
        .packed_res (rounded_s)
    );

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op1_r       <= {MANT_W{1'b0}};
            op2_r       <= {MANT_W{1'b0}};
            mag_r       <= 47'd0;
            exp_r       <= 10'd0;
            sign_r      <= 1'b0;
            zero_r      <= 1'b0;
            zero_sign_r <= 1'b0;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            result_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        op1_r      <= mant_op_1;
                        op2_r      <= mant_op_2;
                        exp_r      <= (exp_max == 8'd0) ? 10'd1 : {2'b00, exp_max};
                        sign_r     <= res_sig;
                        zero_r     <= 1'b0;
                        if (!legal) begin
                            result_r    <= NaN_res ? FP32_QNAN : {res_sig, EXP_INF, 23'd0};
                            res_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    mag_r       <= mag_s;
                    zero_sign_r <= sign_r & (op1_r == {MANT_W{1'b0}}) & (op2_r == {MANT_W{1'b0}});
                    if (mag_s == 47'd0) begin
                        zero_r  <= 1'b1;
                        state_r <= ST_ROUND;
                    end else if (mag_s[MANT_W-2] || (!mag_s[HIDDEN_BIT] && exp_r > 10'd1)) begin
                        state_r <= ST_NORM;
                    end else begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_NORM: begin
                    mag_r <= norm_mag_s;
                    exp_r <= norm_exp_s;
                    if (norm_mag_s[HIDDEN_BIT] || norm_exp_s == 10'd1) begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    result_r    <= zero_r ? {zero_sign_r, 31'd0} : rounded_s;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed bench for fp_add_normalizer: hand-computed results and latencies.
module tb_fp_add_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        NaN_res;
    logic        inf_res;
    logic        legal;
    logic        res_sig;
    logic [7:0]  exp_max;
    logic [47:0] mant_op_1;
    logic [47:0] mant_op_2;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;

    int total_cnt;
    int passed_cnt;
    int failed_cnt;

    fp_add_normalizer #(.NORM_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .NaN_res   (NaN_res),
        .inf_res   (inf_res),
        .legal     (legal),
        .res_sig   (res_sig),
        .exp_max   (exp_max),
        .mant_op_1 (mant_op_1),
        .mant_op_2 (mant_op_2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            failed_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a negedge, measure latency, hold result, then hand it off.
    task automatic run_op(input string tag, input logic [7:0] e, input logic [47:0] m1,
                          input logic [47:0] m2, input logic sg, input logic lg,
                          input logic nan, input logic inf, input logic [31:0] exp_res,
                          input int exp_cyc, input int hold);
        int cyc;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        exp_max = e; mant_op_1 = m1; mant_op_2 = m2;
        res_sig = sg; legal = lg; NaN_res = nan; inf_res = inf;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_result"}, result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, result, exp_res);
            check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_after_hs"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        total_cnt = 0; passed_cnt = 0; failed_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        NaN_res = 1'b0; inf_res = 1'b0; legal = 1'b0; res_sig = 1'b0;
        exp_max = 8'd0; mant_op_1 = 48'd0; mant_op_2 = 48'd0;

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_result", result, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("one_plus_one",   8'd127, 48'h2000_0000_0000, 48'h2000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 4, 0);
        run_op("one_minus_one",  8'd127, 48'h2000_0000_0000, 48'hE000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3, 0);
        run_op("onehalf_minus1", 8'd127, 48'h3000_0000_0000, 48'hE000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3F00_0000, 4, 0);
        run_op("rne_tie_even",   8'd127, 48'h2000_0020_0000, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3F80_0000, 3, 0);
        run_op("rne_round_up",   8'd127, 48'h2000_0060_0000, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3F80_0002, 3, 0);
        run_op("overflow_inf",   8'd254, 48'h3FFF_FFC0_0000, 48'h3FFF_FFC0_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7F80_0000, 4, 0);
        run_op("neg_result",     8'd127, 48'h2000_0000_0000, 48'hD000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBF00_0000, 4, 0);
        run_op("neg_zero",       8'd127, 48'h0000_0000_0000, 48'h0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3, 0);
        run_op("denormal",       8'd0,   48'h1000_0000_0000, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 3, 0);
        run_op("denorm_to_norm", 8'd0,   48'h1000_0000_0000, 48'h1000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0080_0000, 3, 0);
        run_op("exp_limited",    8'd3,   48'h0400_0000_0000, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 5, 0);
        run_op("worst_case_n45", 8'd127, 48'h0000_0000_0001, 48'h0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2900_0000, 48, 0);
        run_op("special_inf",    8'd0,   48'h0000_0000_0000, 48'h0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF80_0000, 1, 0);
        run_op("special_nan_bp", 8'd0,   48'h0000_0000_0000, 48'h0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FC0_0000, 1, 5);

        // Abort a long normalisation with reset partway through
        check("mid_norm_in_ready", {31'd0, in_ready}, 32'd1);
        exp_max = 8'd127; mant_op_1 = 48'h0000_0000_0001; mant_op_2 = 48'd0;
        res_sig = 1'b0; legal = 1'b1; NaN_res = 1'b0; inf_res = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_norm_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_norm_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_norm_rst_result", result, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_norm_idle_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 50; i++) @(negedge clk);
        check("mid_norm_no_result", {31'd0, res_valid}, 32'd0);

        run_op("after_reset", 8'd127, 48'h2000_0000_0000, 48'h2000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 4, 0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_add_normalizer.md
# fp_add_normalizer

Back-end stage of the FP32 adder, directly downstream of the operand preparer. Accepts the preparer's aligned 48-bit two's-complement mantissas, common exponent and special-case flags over a valid/ready handshake. Sums the mantissas and normalises iteratively via a small FSM, then rounds to nearest-even. Delivers a packed IEEE-754 single-precision result over a second valid/ready handshake.

## Interface
- `NORM_STEP`, default 1: maximum left-shift distance per normalisation cycle; legal values are 1, 2, 4 and 8.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  preparer outputs below are valid.
- `in_ready`  out  1  block can accept a new operation.
- `NaN_res`, `inf_res`, `legal`, `res_sig`  in  1 each  special-case flags and result sign from the preparer.
- `exp_max`  in  8  biased exponent of bit 45 of both mantissas.
- `mant_op_1`, `mant_op_2`  in  48 each  aligned two's-complement mantissas.
- `res_valid`  out  1  `result` is valid.
- `res_ready`  in  1  consumer accepts `result`.
- `result`  out  32  packed FP32 result.

## Operation
- **Mantissa format**
  - Hidden bit is bit 45; fraction occupies bits 44..22; bits 21..0 hold shifted-out guard/sticky bits.
  - Magnitude is < 2^46 per operand, so the 48-bit sum never overflows.
  - `exp_max` = 0 (denormal region) is treated as effective exponent 1.
- **FSM states:** IDLE, ADD, NORM, ROUND, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, capture all inputs.
  - If `legal`=0, go to DONE with the special result:
    - `NaN_res`=1 gives 32'h7FC00000.
    - Otherwise `inf_res`=1 gives {res_sig, 8'hFF, 23'h0}.
  - If `legal`=1, go to ADD.
- **ADD**
  - Compute s = mant_op_1 + mant_op_2 and m = |s| (47-bit).
  - If m = 0: result is {res_sig & both inputs zero, 31'h0}; go to ROUND, which passes the value unchanged.
  - Else if m[46]=1 or (m[45]=0 and exp>1): go to NORM.
  - Else: go to ROUND.
- **NORM**
  - If m[46]=1: shift m right by 1, OR the dropped bit into bit 0 (sticky), exp+1; takes one cycle.
  - Else, per cycle: shift left by min(NORM_STEP, leading zeros above bit 45, exp-1) and decrement exp by the same amount.
  - Leave NORM when m[45]=1, or exp=1 (denormal).
- **ROUND**
  - Guard = m[21]; sticky = |m[20:0]; lsb = m[22].
  - Increment m[45:22] when guard & (sticky | lsb).
  - If the increment carries into bit 46: shift right 1, exp+1.
  - Exponent field = exp if m[45]=1, else 0 (denormal). A denormal that rounds up into bit 45 naturally yields field 1.
  - exp ≥ 255 gives {sign, 8'hFF, 23'h0}.
  - Go to DONE.
- **DONE**
  - `res_valid`=1; `result` is stable.
  - On `res_ready`, go to IDLE.
- **Sign:** `res_sig` for non-zero legal results.

## Timing
- **Reset values:** `in_ready`=0 during reset and 1 after release (IDLE); `res_valid`=0; `result`=32'h0; state IDLE; internal registers 0.
- **Reset mid-operation:** the in-flight operation is discarded immediately; no partial result is emitted.
- **Latency**, with input accepted at cycle 0:
  - Legal operations: `res_valid` at cycle 3+N, where N is the number of NORM cycles (0 if already normalised or zero).
  - Special (`legal`=0) operations: `res_valid` at cycle 1.
- **Throughput:** one operation in flight; `in_ready`=0 outside IDLE.
- **Backpressure:** `result` and `res_valid` hold indefinitely while `res_ready`=0. The earliest next accept is the cycle after the `res_valid` & `res_ready` handshake.
- **Worst case:** N = 45 with NORM_STEP=1.

## Structure
- **Shared package `fp32_pkg`:**
  - Constants: FP32_QNAN=32'h7FC00000, EXP_INF=8'hFF, HIDDEN_BIT=45, FRAC_LSB=22, MANT_W=48.
  - FSM state enum.
- **Sub-module `fp_rounder`:** combinational RNE increment, carry and exponent-field packing; used by ROUND.
- Estimated 200–300 lines of RTL.

## Test plan
- **1.0 + 1.0:** exp_max=127, both mantissas 48'h2000_0000_0000 → NORM right shift, `result`=32'h40000000, `res_valid` at cycle 4.
- **1.0 + (−1.0):** mant_op_2=48'hE000_0000_0000, res_sig=0 → `result`=32'h00000000 at cycle 3.
- **1.5 − 1.0:** mant_op_1=48'h3000_0000_0000, mant_op_2=48'hE000_0000_0000 → one left shift, `result`=32'h3F000000 at cycle 4.
- **Round to nearest-even:**
  - exp_max=127, mant_op_1=48'h2000_0020_0000, mant_op_2=0 → tie to even, `result`=32'h3F800000.
  - mant_op_1=48'h2000_0060_0000 → rounds up, `result`=32'h3F800002.
- **Overflow:** exp_max=254, both mantissas 48'h3FFF_FFC0_0000, res_sig=0 → `result`=32'h7F800000.
- **Special case with backpressure and reset:**
  - `legal`=0, `NaN_res`=1 → 32'h7FC00000 at cycle 1.
  - Hold `res_ready`=0 for 5 cycles → `result` stable and `in_ready`=0 throughout.
  - Assert `rst_n`=0 mid-NORM → `res_valid`=0 and IDLE immediately.
